// File: rtl/gpu_vtx_dispatch.sv
// Vertex dispatcher: buffers mem_mgr vertices in a FIFO tagged with an object ID,
// offers them round-robin to LANES pipeline lanes, collects lane results in dispatch
// order, drops exception results (counted) and drives one registered pixel stream.
//
// Ports:
//   iClock, iReset               clock, synchronous active-high reset
//   iEnable/iInitObj/iInitVtx    mem_mgr controls; iVertexX/Y/Z vertex coordinates
//   oVtxReady, oOverflow         FIFO has room; sticky dropped-vertex flag
//   oLaneValid/iLaneReady        one-hot vertex offer / per-lane accept
//   oLaneX/Y/Z, oLaneObj         shared vertex bus (FIFO head) and its object ID
//   iResValid/iResX/iResY/iResExc, oResReady   per-lane result handshake
//   oPixValid/oPixX/oPixY/oPixObj, iPixReady   registered pixel output
//   oExcCount, oBusy             saturating exception count; activity flag
module gpu_vtx_dispatch #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned OBJ_W  = 4
) (
  input  logic                      iClock,
  input  logic                      iReset,
  input  logic                      iEnable,
  input  logic                      iInitObj,
  input  logic                      iInitVtx,
  input  logic [DATA_W-1:0]         iVertexX,
  input  logic [DATA_W-1:0]         iVertexY,
  input  logic [DATA_W-1:0]         iVertexZ,
  output logic                      oVtxReady,
  output logic                      oOverflow,
  output logic [LANES-1:0]          oLaneValid,
  input  logic [LANES-1:0]          iLaneReady,
  output logic [DATA_W-1:0]         oLaneX,
  output logic [DATA_W-1:0]         oLaneY,
  output logic [DATA_W-1:0]         oLaneZ,
  output logic [OBJ_W-1:0]          oLaneObj,
  input  logic [LANES-1:0]          iResValid,
  input  logic [LANES*DATA_W-1:0]   iResX,
  input  logic [LANES*DATA_W-1:0]   iResY,
  input  logic [LANES-1:0]          iResExc,
  output logic [LANES-1:0]          oResReady,
  output logic                      oPixValid,
  output logic [DATA_W-1:0]         oPixX,
  output logic [DATA_W-1:0]         oPixY,
  output logic [OBJ_W-1:0]          oPixObj,
  input  logic                      iPixReady,
  output logic [15:0]               oExcCount,
  output logic                      oBusy
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned InfW  = $clog2(DEPTH * LANES + 1);
  localparam logic [InfW-1:0]  InfMax   = InfW'(DEPTH * LANES);
  localparam logic [LaneW-1:0] LaneLast = LaneW'(LANES - 1);

  // Vertex FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [DATA_W-1:0] fifo_x_q   [DEPTH];
  logic [DATA_W-1:0] fifo_y_q   [DEPTH];
  logic [DATA_W-1:0] fifo_z_q   [DEPTH];
  logic [OBJ_W-1:0]  fifo_obj_q [DEPTH];
  logic [PtrW:0]     wptr_q, rptr_q;
  logic [OBJ_W-1:0]  obj_q, obj_d;

  // Per-lane object ID FIFOs; occupancy is bounded by the in-flight cap and
  // round-robin dispatch, so no full/empty tracking is needed.
  logic [OBJ_W-1:0]  id_q      [LANES][DEPTH];
  logic [PtrW-1:0]   id_wptr_q [LANES];
  logic [PtrW-1:0]   id_rptr_q [LANES];

  logic [LaneW-1:0]  dptr_q, cptr_q;
  logic [InfW-1:0]   inflight_q;
  logic [15:0]       exc_cnt_q;
  logic              overflow_q;
  logic              pix_valid_q;
  logic [DATA_W-1:0] pix_x_q, pix_y_q;
  logic [OBJ_W-1:0]  pix_obj_q;

  logic              empty, full, push, dispatch, collect_en, collect;
  logic [PtrW-1:0]   rd_idx, wr_idx;
  logic              lane_rdy_sel, res_valid_sel, res_exc_sel;
  logic [DATA_W-1:0] res_x_sel, res_y_sel;
  logic [OBJ_W-1:0]  res_obj_sel;
  logic              disp_valid;

  assign rd_idx = rptr_q[PtrW-1:0];
  assign wr_idx = wptr_q[PtrW-1:0];
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[PtrW] != rptr_q[PtrW]) && (wr_idx == rd_idx);
  assign push   = iEnable && iInitVtx && !full;
  // A vertex arriving with iInitObj belongs to the new object
  assign obj_d  = obj_q + OBJ_W'(iEnable && iInitObj);

  // Lane-selected handshake and result signals
  always_comb begin
    lane_rdy_sel  = 1'b0;
    res_valid_sel = 1'b0;
    res_exc_sel   = 1'b0;
    res_x_sel     = '0;
    res_y_sel     = '0;
    res_obj_sel   = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (dptr_q == LaneW'(k)) lane_rdy_sel = iLaneReady[k];
      if (cptr_q == LaneW'(k)) begin
        res_valid_sel = iResValid[k];
        res_exc_sel   = iResExc[k];
        res_x_sel     = iResX[k*DATA_W +: DATA_W];
        res_y_sel     = iResY[k*DATA_W +: DATA_W];
        res_obj_sel   = id_q[k][id_rptr_q[k]];
      end
    end
  end

  assign disp_valid = !empty && (inflight_q != InfMax);
  assign dispatch   = disp_valid && lane_rdy_sel;
  // Only accept a result when the pixel register is free or draining this cycle
  assign collect_en = (inflight_q != '0) && (!pix_valid_q || iPixReady);
  assign collect    = collect_en && res_valid_sel;

  assign oVtxReady  = !full;
  assign oOverflow  = overflow_q;
  assign oLaneValid = disp_valid ? (LANES'(1) << dptr_q) : '0;
  assign oLaneX     = fifo_x_q[rd_idx];
  assign oLaneY     = fifo_y_q[rd_idx];
  assign oLaneZ     = fifo_z_q[rd_idx];
  assign oLaneObj   = fifo_obj_q[rd_idx];
  assign oResReady  = collect_en ? (LANES'(1) << cptr_q) : '0;
  assign oPixValid  = pix_valid_q;
  assign oPixX      = pix_x_q;
  assign oPixY      = pix_y_q;
  assign oPixObj    = pix_obj_q;
  assign oExcCount  = exc_cnt_q;
  assign oBusy      = !empty || (inflight_q != '0) || pix_valid_q;

  // Data storage, not reset: validity is tracked by the pointers
  always_ff @(posedge iClock) begin
    if (push) begin
      fifo_x_q[wr_idx]   <= iVertexX;
      fifo_y_q[wr_idx]   <= iVertexY;
      fifo_z_q[wr_idx]   <= iVertexZ;
      fifo_obj_q[wr_idx] <= obj_d;
    end
    if (dispatch) id_q[dptr_q][id_wptr_q[dptr_q]] <= fifo_obj_q[rd_idx];
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      obj_q       <= '0;
      dptr_q      <= '0;
      cptr_q      <= '0;
      inflight_q  <= '0;
      exc_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_obj_q   <= '0;
      for (int unsigned k = 0; k < LANES; k++) begin
        id_wptr_q[k] <= '0;
        id_rptr_q[k] <= '0;
      end
    end else begin
      obj_q <= obj_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (iEnable && iInitVtx && full) overflow_q <= 1'b1;
      if (dispatch) begin
        rptr_q            <= rptr_q + 1'b1;
        dptr_q            <= (dptr_q == LaneLast) ? '0 : dptr_q + 1'b1;
        id_wptr_q[dptr_q] <= id_wptr_q[dptr_q] + 1'b1;
      end
      if (collect) begin
        cptr_q            <= (cptr_q == LaneLast) ? '0 : cptr_q + 1'b1;
        id_rptr_q[cptr_q] <= id_rptr_q[cptr_q] + 1'b1;
      end
      unique case ({dispatch, collect})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: ;
      endcase
      if (collect && res_exc_sel && (exc_cnt_q != 16'hFFFF)) exc_cnt_q <= exc_cnt_q + 16'd1;
      if (collect && !res_exc_sel) begin
        pix_valid_q <= 1'b1;
        pix_x_q     <= res_x_sel;
        pix_y_q     <= res_y_sel;
        pix_obj_q   <= res_obj_sel;
      end else if (iPixReady) begin
        pix_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpu_vtx_dispatch.sv
// Self-checking bench for gpu_vtx_dispatch. Lanes are modelled as in-order queues
// that return X*10, Y+Z and flag an exception when Z[15] is set.
module tb_gpu_vtx_dispatch;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int LANES  = 2;
  localparam int OBJ_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [OBJ_W-1:0]  obj;
    logic              exc;
  } res_t;

  logic iClock = 1'b0, iReset, iEnable, iInitObj, iInitVtx, iPixReady;
  logic [DATA_W-1:0] iVertexX, iVertexY, iVertexZ;
  logic oVtxReady, oOverflow, oPixValid, oBusy;
  logic [LANES-1:0] oLaneValid, iLaneReady, iResValid, iResExc, oResReady;
  logic [DATA_W-1:0] oLaneX, oLaneY, oLaneZ, oPixX, oPixY;
  logic [OBJ_W-1:0] oLaneObj, oPixObj;
  logic [LANES*DATA_W-1:0] iResX, iResY;
  logic [15:0] oExcCount;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_pct  = 0;
  int res_pct  = 0;
  logic [LANES-1:0] res_mask = '0;
  int xfers;
  res_t lane_q [LANES][$];
  res_t pix_seen [$];
  res_t exp_q [$];

  always #5 iClock = ~iClock;

  gpu_vtx_dispatch #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES), .OBJ_W(OBJ_W)) dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iInitObj(iInitObj),
    .iInitVtx(iInitVtx), .iVertexX(iVertexX), .iVertexY(iVertexY), .iVertexZ(iVertexZ),
    .oVtxReady(oVtxReady), .oOverflow(oOverflow), .oLaneValid(oLaneValid),
    .iLaneReady(iLaneReady), .oLaneX(oLaneX), .oLaneY(oLaneY), .oLaneZ(oLaneZ),
    .oLaneObj(oLaneObj), .iResValid(iResValid), .iResX(iResX), .iResY(iResY),
    .iResExc(iResExc), .oResReady(oResReady), .oPixValid(oPixValid), .oPixX(oPixX),
    .oPixY(oPixY), .oPixObj(oPixObj), .iPixReady(iPixReady), .oExcCount(oExcCount),
    .oBusy(oBusy)
  );

  function automatic res_t lane_fn(logic [DATA_W-1:0] x, logic [DATA_W-1:0] y,
                                   logic [DATA_W-1:0] z, logic [OBJ_W-1:0] obj);
    res_t r;
    r.x = x * 16'd10;
    r.y = y + z;
    r.obj = obj;
    r.exc = z[15];
    return r;
  endfunction

  // One clock: drive lane-side inputs, log handshakes that fire at the coming edge.
  task automatic tick();
    for (int k = 0; k < LANES; k++) begin
      iLaneReady[k] = ($urandom_range(99) < rdy_pct);
      iResValid[k]  = res_mask[k] && (lane_q[k].size() > 0) && ($urandom_range(99) < res_pct);
      if (lane_q[k].size() > 0) begin
        iResX[k*DATA_W +: DATA_W] = lane_q[k][0].x;
        iResY[k*DATA_W +: DATA_W] = lane_q[k][0].y;
        iResExc[k] = lane_q[k][0].exc;
      end
    end
    #1;
    xfers = 0;
    for (int k = 0; k < LANES; k++) begin
      if (oLaneValid[k] && iLaneReady[k]) begin
        lane_q[k].push_back(lane_fn(oLaneX, oLaneY, oLaneZ, oLaneObj));
        xfers++;
      end
      if (oResReady[k] && iResValid[k]) void'(lane_q[k].pop_front());
    end
    if (oPixValid && iPixReady) pix_seen.push_back({oPixX, oPixY, oPixObj, 1'b0});
    @(posedge iClock);
    @(negedge iClock);
  endtask

  task automatic idle_in();
    iEnable = 0; iInitObj = 0; iInitVtx = 0;
    iVertexX = '0; iVertexY = '0; iVertexZ = '0;
  endtask

  task automatic set_vtx(int x, int y, int z, logic obj);
    iEnable = 1; iInitVtx = 1; iInitObj = obj;
    iVertexX = DATA_W'(x); iVertexY = DATA_W'(y); iVertexZ = DATA_W'(z);
  endtask

  task automatic do_reset();
    idle_in();
    iReset = 1; iLaneReady = '0; iResValid = '0; iResExc = '0; iResX = '0; iResY = '0;
    iPixReady = 0; rdy_pct = 0; res_pct = 0; res_mask = '0;
    @(posedge iClock); @(negedge iClock);
    iReset = 0;
    for (int k = 0; k < LANES; k++) lane_q[k].delete();
    pix_seen.delete();
    exp_q.delete();
  endtask

  task automatic drain(int budget);
    idle_in();
    rdy_pct = 100; res_pct = 100; res_mask = '1; iPixReady = 1;
    for (int c = 0; c < budget && oBusy; c++) tick();
    tick();
    n_checks++;
    if (oBusy !== 1'b0) begin n_fail++; $display("FAIL drain_busy: got %b want 0", oBusy); end
  endtask

  task automatic cmp_pixels(string name);
    n_checks++;
    if (pix_seen.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d want %0d", name, pix_seen.size(), exp_q.size());
    end
    for (int i = 0; i < pix_seen.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (pix_seen[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_pix%0d: got x=%0d y=%0d obj=%0d want x=%0d y=%0d obj=%0d", name, i,
                 pix_seen[i].x, pix_seen[i].y, pix_seen[i].obj, exp_q[i].x, exp_q[i].y,
                 exp_q[i].obj);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 7;
    if (oVtxReady !== 1'b1) begin n_fail++; $display("FAIL rst_vtxready: got %b want 1", oVtxReady); end
    if (oOverflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", oOverflow); end
    if (oLaneValid !== 2'b00) begin n_fail++; $display("FAIL rst_lanevalid: got %b want 00", oLaneValid); end
    if (oResReady !== 2'b00) begin n_fail++; $display("FAIL rst_resready: got %b want 00", oResReady); end
    if (oPixValid !== 1'b0) begin n_fail++; $display("FAIL rst_pixvalid: got %b want 0", oPixValid); end
    if (oExcCount !== 16'd0) begin n_fail++; $display("FAIL rst_exccount: got %0d want 0", oExcCount); end
    if (oBusy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", oBusy); end
  endtask

  task automatic test_dispatch();
    logic [LANES-1:0] exp_lv [5];
    int vx [3];
    exp_lv[0] = 2'b00; exp_lv[1] = 2'b01; exp_lv[2] = 2'b10; exp_lv[3] = 2'b01; exp_lv[4] = 2'b00;
    vx[0] = 1; vx[1] = 4; vx[2] = 7;
    do_reset();
    rdy_pct = 100; iPixReady = 1;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) set_vtx(vx[c], vx[c] + 1, vx[c] + 2, 0);
      else idle_in();
      n_checks++;
      if (oLaneValid !== exp_lv[c]) begin
        n_fail++; $display("FAIL disp_lanevalid_c%0d: got %b want %b", c, oLaneValid, exp_lv[c]);
      end
      if (c >= 1 && c <= 3) begin
        n_checks++;
        if (oLaneX !== DATA_W'(vx[c-1])) begin
          n_fail++; $display("FAIL disp_bus_c%0d: got %0d want %0d", c, oLaneX, vx[c-1]);
        end
      end
      tick();
    end
    n_checks += 2;
    if (lane_q[0].size() != 2 || lane_q[1].size() != 1) begin
      n_fail++; $display("FAIL disp_inflight: got %0d/%0d want 2/1", lane_q[0].size(), lane_q[1].size());
    end
    if (oResReady !== 2'b01) begin n_fail++; $display("FAIL disp_resready: got %b want 01", oResReady); end
  endtask

  task automatic test_out_of_order();
    res_mask = 2'b10; res_pct = 100; rdy_pct = 100; iPixReady = 1;
    for (int c = 0; c < 3; c++) begin
      n_checks += 2;
      if (oResReady !== 2'b01) begin n_fail++; $display("FAIL ooo_resready_c%0d: got %b want 01", c, oResReady); end
      if (oPixValid !== 1'b0) begin n_fail++; $display("FAIL ooo_pixvalid_c%0d: got %b want 0", c, oPixValid); end
      tick();
    end
    exp_q.push_back(lane_fn(1, 2, 3, 0));
    exp_q.push_back(lane_fn(4, 5, 6, 0));
    exp_q.push_back(lane_fn(7, 8, 9, 0));
    drain(40);
    cmp_pixels("ooo");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (oVtxReady !== (i < 8)) begin n_fail++; $display("FAIL ovf_ready_%0d: got %b want %b", i, oVtxReady, i < 8); end
      set_vtx(i + 1, i, i, 0);
      if (i < 8) exp_q.push_back(lane_fn(DATA_W'(i + 1), DATA_W'(i), DATA_W'(i), 0));
      tick();
    end
    idle_in();
    n_checks += 2;
    if (oVtxReady !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_full: got %b want 0", oVtxReady); end
    if (oOverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", oOverflow); end
    drain(80);
    cmp_pixels("ovf");
    n_checks++;
    if (oOverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", oOverflow); end
  endtask

  task automatic test_inflight_cap();
    do_reset();
    rdy_pct = 100;
    for (int i = 0; i < 17; i++) begin
      set_vtx(i, 1, 1, 0);
      exp_q.push_back(lane_fn(DATA_W'(i), 1, 1, 0));
      tick();
    end
    idle_in();
    for (int c = 0; c < 4; c++) tick();
    n_checks += 2;
    if (oLaneValid !== 2'b00) begin n_fail++; $display("FAIL cap_lanevalid: got %b want 00", oLaneValid); end
    if (lane_q[0].size() + lane_q[1].size() != DEPTH * LANES) begin
      n_fail++; $display("FAIL cap_inflight: got %0d want %0d", lane_q[0].size() + lane_q[1].size(), DEPTH * LANES);
    end
    drain(120);
    cmp_pixels("cap");
  endtask

  task automatic test_obj_id();
    do_reset();
    iInitObj = 1; iEnable = 0; tick();
    iEnable = 1; tick(); tick();
    set_vtx(11, 0, 0, 0); tick();
    set_vtx(12, 0, 0, 1); tick();
    idle_in();
    n_checks += 2;
    if (oLaneObj !== 4'd2) begin n_fail++; $display("FAIL obj_first: got %0d want 2", oLaneObj); end
    if (oLaneX !== 16'd11) begin n_fail++; $display("FAIL obj_first_x: got %0d want 11", oLaneX); end
    rdy_pct = 100; tick(); rdy_pct = 0;
    n_checks++;
    if (oLaneObj !== 4'd3) begin n_fail++; $display("FAIL obj_same_cycle: got %0d want 3", oLaneObj); end
    exp_q.push_back(lane_fn(11, 0, 0, 2));
    exp_q.push_back(lane_fn(12, 0, 0, 3));
    drain(40);
    cmp_pixels("obj");
  endtask

  task automatic test_exception();
    logic [DATA_W-1:0] held;
    do_reset();
    rdy_pct = 100; res_pct = 100; res_mask = '1; iPixReady = 1;
    set_vtx(1, 2, 3, 0); tick();
    set_vtx(2, 2, 16'h8000, 0); tick();
    set_vtx(3, 3, 3, 0); tick();
    idle_in();
    for (int c = 0; c < 10; c++) tick();
    exp_q.push_back(lane_fn(1, 2, 3, 0));
    exp_q.push_back(lane_fn(3, 3, 3, 0));
    cmp_pixels("exc");
    n_checks++;
    if (oExcCount !== 16'd1) begin n_fail++; $display("FAIL exc_count: got %0d want 1", oExcCount); end
    iPixReady = 0;
    set_vtx(5, 1, 1, 0); tick();
    set_vtx(6, 1, 1, 0); tick();
    idle_in();
    for (int c = 0; c < 10; c++) tick();
    held = 16'd50;
    for (int c = 0; c < 3; c++) begin
      n_checks += 3;
      if (oPixValid !== 1'b1) begin n_fail++; $display("FAIL exc_hold_valid_c%0d: got %b want 1", c, oPixValid); end
      if (oPixX !== held) begin n_fail++; $display("FAIL exc_hold_x_c%0d: got %0d want %0d", c, oPixX, held); end
      if (oResReady !== 2'b00) begin n_fail++; $display("FAIL exc_hold_resready_c%0d: got %b want 00", c, oResReady); end
      tick();
    end
    exp_q.push_back(lane_fn(5, 1, 1, 0));
    exp_q.push_back(lane_fn(6, 1, 1, 0));
    drain(40);
    cmp_pixels("exc_bp");
  endtask

  task automatic test_random();
    int occ = 0;
    int exc_m = 0;
    logic ovf_m = 0;
    logic [OBJ_W-1:0] obj_m = '0;
    logic acc;
    res_t r;
    do_reset();
    rdy_pct = 70; res_pct = 60; res_mask = '1;
    for (int c = 0; c < 1500; c++) begin
      iEnable  = ($urandom_range(3) != 0);
      iInitObj = ($urandom_range(7) == 0);
      iInitVtx = $urandom_range(1);
      iVertexX = DATA_W'($urandom); iVertexY = DATA_W'($urandom);
      iVertexZ = {($urandom_range(5) == 0), 15'($urandom)};
      iPixReady = ($urandom_range(3) != 0);
      if (iEnable && iInitObj) obj_m = obj_m + 1'b1;
      n_checks++;
      if (oVtxReady !== (occ < DEPTH)) begin
        n_fail++; $display("FAIL rnd_ready_c%0d: got %b want %b", c, oVtxReady, occ < DEPTH);
      end
      acc = iEnable && iInitVtx && (occ < DEPTH);
      if (iEnable && iInitVtx && occ >= DEPTH) ovf_m = 1;
      if (acc) begin
        r = lane_fn(iVertexX, iVertexY, iVertexZ, obj_m);
        if (r.exc) exc_m++;
        else exp_q.push_back(r);
      end
      tick();
      occ = occ + int'(acc) - xfers;
    end
    drain(300);
    cmp_pixels("rnd");
    n_checks += 2;
    if (oExcCount !== 16'(exc_m)) begin n_fail++; $display("FAIL rnd_exccount: got %0d want %0d", oExcCount, exc_m); end
    if (oOverflow !== ovf_m) begin n_fail++; $display("FAIL rnd_overflow: got %b want %b", oOverflow, ovf_m); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) begin set_vtx(i + 1, 1, 1, 0); tick(); end
    idle_in();
    rdy_pct = 100; tick(); tick(); rdy_pct = 0;
    iEnable = 1; iInitObj = 1; tick(); idle_in();
    n_checks++;
    if (oBusy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", oBusy); end
    iReset = 1; @(posedge iClock); @(negedge iClock); iReset = 0;
    n_checks += 5;
    if (oBusy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", oBusy); end
    if (oLaneValid !== 2'b00) begin n_fail++; $display("FAIL mid_lanevalid: got %b want 00", oLaneValid); end
    if (oResReady !== 2'b00) begin n_fail++; $display("FAIL mid_resready: got %b want 00", oResReady); end
    if (oExcCount !== 16'd0) begin n_fail++; $display("FAIL mid_exccount: got %0d want 0", oExcCount); end
    if (oVtxReady !== 1'b1) begin n_fail++; $display("FAIL mid_vtxready: got %b want 1", oVtxReady); end
    for (int k = 0; k < LANES; k++) lane_q[k].delete();
    set_vtx(9, 0, 0, 0); tick(); idle_in();
    n_checks++;
    if (oLaneObj !== 4'd0 || oLaneX !== 16'd9) begin
      n_fail++; $display("FAIL mid_after: got obj=%0d x=%0d want obj=0 x=9", oLaneObj, oLaneX);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge iClock);
    test_reset();
    test_dispatch();
    test_out_of_order();
    test_overflow();
    test_inflight_cap();
    test_obj_id();
    test_exception();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
